calc_stack: RTL
===============

# calc_stack

Parametrised successor to the single-accumulator calculator: a WIDTH-bit RPN calculator with a DEPTH-entry operand stack, edge-triggered command entry, and an iterative multiplier. It sits between the board's buttons/switches and the LEDs. Commands are selected by btnl/btnc/btnr and executed on a rising edge of btnd. Top-of-stack is shown on led.

## Interface
- WIDTH, 16: operand/result width in bits (≥4).
- DEPTH, 8: stack entries (≥2).
- CW, $clog2(DEPTH+1): width of the count output.
- clk  in  1  single system clock, all logic on posedge.
- btnu  in  1  synchronous active-high reset.
- btnd  in  1  execute button, level; rising edge triggers a command.
- btnl, btnc, btnr  in  1 each  command select, sampled in the trigger cycle.
- sw  in  WIDTH  operand for PUSH, sampled in the trigger cycle.
- led  out  WIDTH  top of stack (T); 0 when stack empty.
- count  out  CW  number of valid entries, 0..DEPTH.
- busy  out  1  multiply in progress.
- err  out  1  sticky stack error (overflow/underflow).
- ovf  out  1  sticky signed arithmetic overflow.

## Operation
- Button inputs are already synchronous to clk. btnd_q is the registered btnd. trigger = btnd & ~btnd_q.
- T = top entry, N = entry below T. Command code = {btnl,btnc,btnr}:
  - 000 PUSH: push sw.
  - 001 POP: discard T.
  - 010 ADD: pop T and N, push N+T.
  - 011 SUB: pop T and N, push N−T.
  - 100 AND: pop T and N, push N&T.
  - 101 XOR: pop T and N, push N^T.
  - 110 MUL: pop T and N, push the low WIDTH bits of N*T (two's complement); multi-cycle.
  - 111 CLEAR: count←0, err←0, ovf←0.
- Binary ops (ADD..MUL) net-decrement count by 1.
- Error checks; on either error the stack and count are unchanged and err←1:
  - PUSH when count==DEPTH.
  - POP when count==0.
  - Binary op when count<2.
- ADD/SUB signed overflow sets ovf←1. The wrapped result is still pushed.
  - MUL never sets ovf; truncation is silent.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- MUL is shift-add over WIDTH iterations.
  - Operands are latched at trigger.
  - The stack is not modified until completion.
  - A trigger while busy is ignored entirely: no state change, no err.
- Reset (btnu) has priority over everything. It aborts an in-flight MUL with no writeback.
- Reset values: count=0, led=0, busy=0, err=0, ovf=0, multiplier state idle. btnd_q resets to 1, so a btnd held through reset does not fire.
- Stack storage contents need no reset; led must read 0 when count==0.

## Timing
- Single-cycle commands: trigger in cycle k; led/count/err/ovf reflect the result from cycle k+1.
- MUL: trigger in cycle k.
  - busy=1 for cycles k+1 .. k+WIDTH.
  - In cycle k+WIDTH+1: busy=0, led=product, count decremented.
- A held btnd produces exactly one trigger. The next trigger requires btnd low for ≥1 cycle.
- btnd low-high-low pulses of 1 cycle each are all valid triggers.
- Reset asserted in cycle k: all outputs at reset values from k+1. A trigger in cycle k is discarded.
- MUL with count<2 is an underflow error in cycle k+1; busy never rises.

## Test plan
- WIDTH=16, DEPTH=8. PUSH 0x0005, PUSH 0x0003, SUB -> led=0x0002, count=1, err=0, ovf=0.
- PUSH 0x7FFF, PUSH 0x0001, ADD -> led=0x8000, ovf=1, count=1. CLEAR -> ovf=0, count=0, led=0.
- PUSH 0xFFFD (−3), PUSH 0x0007, MUL -> busy high exactly 16 cycles, then led=0xFFEB (−21), count=1. btnd edges during busy change nothing.
- 8 PUSHes of 1..8, then a 9th PUSH 0x00AA -> err=1, count=8, led=0x0008. POP ×8 -> count=0, led=0. POP -> err stays 1, count=0.
- Hold btnd high 20 cycles with PUSH selected -> exactly one push. Reset asserted while btnd high, then released with btnd still high -> no trigger.
- Reset in the middle of a MUL (cycle k+5) -> busy=0, count=0, led=0 next cycle, no later writeback.

Source files
------------

// File: rtl/calc_stack.sv
`default_nettype none
// ============================================================================
//  Module      : calc_stack
//  Description : WIDTH-bit RPN calculator with a DEPTH-entry operand stack,
//                edge-triggered command entry and a shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             btnu,
  input  logic             btnd,
  input  logic             btnl,
  input  logic             btnc,
  input  logic             btnr,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] led,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             err,
  output logic             ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] CMD_PUSH  = 3'b000;
  localparam logic [2:0] CMD_POP   = 3'b001;
  localparam logic [2:0] CMD_ADD   = 3'b010;
  localparam logic [2:0] CMD_SUB   = 3'b011;
  localparam logic [2:0] CMD_AND   = 3'b100;
  localparam logic [2:0] CMD_XOR   = 3'b101;
  localparam logic [2:0] CMD_MUL   = 3'b110;
  localparam logic [2:0] CMD_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             btnd_q, btnd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    iter_q, iter_d;

  logic [WIDTH-1:0] stk_mem [DEPTH];

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic             trigger;
  logic [2:0]       cmd;
  logic [AW-1:0]    top_idx, nxt_idx, push_idx;
  logic [WIDTH-1:0] val_t, val_n, sum, diff, acc_step;
  logic             add_ovf, sub_ovf;

  assign trigger  = btnd & ~btnd_q;
  assign cmd      = {btnl, btnc, btnr};
  assign top_idx  = AW'(count_q - CW'(1));
  assign nxt_idx  = AW'(count_q - CW'(2));
  assign push_idx = AW'(count_q);
  assign val_t    = stk_mem[top_idx];
  assign val_n    = stk_mem[nxt_idx];
  assign sum      = val_n + val_t;
  assign diff     = val_n - val_t;
  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips away from N.
  assign add_ovf  = (val_n[WIDTH-1] == val_t[WIDTH-1]) && (sum[WIDTH-1]  != val_n[WIDTH-1]);
  assign sub_ovf  = (val_n[WIDTH-1] != val_t[WIDTH-1]) && (diff[WIDTH-1] != val_n[WIDTH-1]);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign led   = (count_q == '0) ? '0 : val_t;
  assign count = count_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign ovf   = ovf_q;

  // Next-state: command decode when idle, one shift-add step per cycle while multiplying.
  always_comb begin
    state_d  = state_q;
    btnd_d   = btnd;
    count_d  = count_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;

    if (state_q == ST_MUL) begin
      // Triggers are ignored here; only the multiplier advances.
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      iter_d   = iter_q + IW'(1);
      if (iter_q == IW'(WIDTH - 1)) begin
        wr_en   = 1'b1;
        wr_idx  = nxt_idx;
        wr_data = acc_step;
        count_d = count_q - CW'(1);
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else if (trigger) begin
      case (cmd)
        CMD_PUSH: begin
          if (count_q == CW'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = push_idx;
            wr_data = sw;
            count_d = count_q + CW'(1);
          end
        end
        CMD_POP: begin
          if (count_q == '0) err_d = 1'b1;
          else               count_d = count_q - CW'(1);
        end
        CMD_CLEAR: begin
          count_d = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
        default: begin
          if (count_q < CW'(2)) begin
            err_d = 1'b1;
          end else if (cmd == CMD_MUL) begin
            mcand_d  = val_n;
            mplier_d = val_t;
            acc_d    = '0;
            iter_d   = '0;
            state_d  = ST_MUL;
            busy_d   = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = nxt_idx;
            count_d = count_q - CW'(1);
            case (cmd)
              CMD_ADD: begin wr_data = sum;  ovf_d = ovf_q | add_ovf; end
              CMD_SUB: begin wr_data = diff; ovf_d = ovf_q | sub_ovf; end
              CMD_AND: wr_data = val_n & val_t;
              default: wr_data = val_n ^ val_t;
            endcase
          end
        end
      endcase
    end
  end

  // State registers; reset aborts any multiply and suppresses the stack write.
  always_ff @(posedge clk) begin
    if (btnu) begin
      state_q  <= ST_IDLE;
      btnd_q   <= 1'b1;
      count_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      btnd_q   <= btnd_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      if (wr_en) stk_mem[wr_idx] <= wr_data;
    end
  end

endmodule
`default_nettype wire
